// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use, jump flush, multi-cycle multiply and memory-busy freeze.
// Optional performance counters are built only when HAZ_PERF_EN is defined.
module hazard_ctrl #(
  parameter int unsigned MUL_LAT = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [4:0]  Raa_id,
  input  logic [4:0]  Rba_id,
  input  logic [4:0]  Rd_ex,
  input  logic        memRead_ex,
  input  logic        jump_ex,
  input  logic        mulStart_ex,
  input  logic        mem_busy,
  output logic        stall_pc,
  output logic        stall_ifid,
  output logic        stall_idie,
  output logic        flush_ifid,
  output logic        flush_idie,
  output logic        bubble_exmem,
  output logic        mul_done,
  output logic [1:0]  state_o,
  output logic [31:0] stall_cnt,
  output logic [31:0] flush_cnt
);

  localparam int unsigned CNT_W = 4;

  typedef enum logic [1:0] {
    RUN = 2'b00,
    MUL = 2'b01
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx;
  logic               load_use;

  assign load_use = memRead_ex && (Rd_ex != 5'd0) &&
                    ((Rd_ex == Raa_id) || (Rd_ex == Rba_id));

  // Priority: reset > mem_busy > MUL > jump > multiply start > load-use
  always_comb begin
    state_nx     = state;
    cnt_nx       = cnt;
    stall_pc     = 1'b0;
    stall_ifid   = 1'b0;
    stall_idie   = 1'b0;
    flush_ifid   = 1'b0;
    flush_idie   = 1'b0;
    bubble_exmem = 1'b0;
    mul_done     = 1'b0;
    if (rst) begin
      if (mem_busy) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        stall_idie = 1'b1;
      end else if (state == MUL) begin
        if (cnt != '0) begin
          stall_pc     = 1'b1;
          stall_ifid   = 1'b1;
          stall_idie   = 1'b1;
          bubble_exmem = 1'b1;
          cnt_nx       = cnt - CNT_W'(1);
        end else begin
          mul_done = 1'b1;
          state_nx = RUN;
        end
      end else if (jump_ex) begin
        flush_ifid = 1'b1;
        flush_idie = 1'b1;
      end else if (mulStart_ex) begin
        stall_pc     = 1'b1;
        stall_ifid   = 1'b1;
        stall_idie   = 1'b1;
        bubble_exmem = 1'b1;
        cnt_nx       = CNT_W'(MUL_LAT - 2);
        state_nx     = MUL;
      end else if (load_use) begin
        stall_pc   = 1'b1;
        stall_ifid = 1'b1;
        flush_idie = 1'b1;
      end
    end
  end

  assign state_o = rst ? state : RUN;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= RUN;
      cnt   <= '0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
    end
  end

`ifdef HAZ_PERF_EN
  logic [31:0] stall_q, flush_q;

  // Saturating event counters
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (stall_pc && (stall_q != 32'hFFFF_FFFF)) stall_q <= stall_q + 32'd1;
      if (flush_ifid && (flush_q != 32'hFFFF_FFFF)) flush_q <= flush_q + 32'd1;
    end
  end

  assign stall_cnt = rst ? stall_q : 32'd0;
  assign flush_cnt = rst ? flush_q : 32'd0;
`else
  assign stall_cnt = 32'd0;
  assign flush_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: directed per-cycle vectors push expected outputs,
// a negedge monitor pops and compares.
module tb_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  Raa_id, Rba_id, Rd_ex;
  logic        memRead_ex, jump_ex, mulStart_ex, mem_busy;
  logic        stall_pc, stall_ifid, stall_idie, flush_ifid, flush_idie;
  logic        bubble_exmem, mul_done;
  logic [1:0]  state_o;
  logic [31:0] stall_cnt, flush_cnt;

  hazard_ctrl #(.MUL_LAT(4)) dut (
    .clk(clk), .rst(rst),
    .Raa_id(Raa_id), .Rba_id(Rba_id), .Rd_ex(Rd_ex),
    .memRead_ex(memRead_ex), .jump_ex(jump_ex), .mulStart_ex(mulStart_ex),
    .mem_busy(mem_busy),
    .stall_pc(stall_pc), .stall_ifid(stall_ifid), .stall_idie(stall_idie),
    .flush_ifid(flush_ifid), .flush_idie(flush_idie),
    .bubble_exmem(bubble_exmem), .mul_done(mul_done), .state_o(state_o),
    .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  always #5 clk = ~clk;

  // {stall_pc, stall_ifid, stall_idie, flush_ifid, flush_idie, bubble, mul_done, state[1:0]}
  localparam logic [8:0] NONE  = 9'b000000000;
  localparam logic [8:0] LU    = 9'b110010000;
  localparam logic [8:0] JMP   = 9'b000110000;
  localparam logic [8:0] MST   = 9'b111001000;
  localparam logic [8:0] MSTL  = 9'b111001001;
  localparam logic [8:0] MDONE = 9'b000000101;
  localparam logic [8:0] BRUN  = 9'b111000000;
  localparam logic [8:0] BMUL  = 9'b111000001;

  typedef struct packed {
    logic [8:0]  o;
    logic [31:0] sc;
    logic [31:0] fc;
    int          idx;
  } exp_t;

  exp_t        q[$];
  int          passed = 0;
  int          total  = 0;
  int          vec    = 0;
  logic [31:0] acc_s  = 0;
  logic [31:0] acc_f  = 0;

  task automatic cyc(input logic r, input logic [4:0] a, input logic [4:0] b,
                     input logic [4:0] d, input logic mr, input logic j,
                     input logic ms, input logic mb, input logic [8:0] eo);
    exp_t e;
    @(posedge clk);
    #1;
    rst = r; Raa_id = a; Rba_id = b; Rd_ex = d;
    memRead_ex = mr; jump_ex = j; mulStart_ex = ms; mem_busy = mb;
    e.o   = eo;
    e.idx = vec;
`ifdef HAZ_PERF_EN
    e.sc = r ? acc_s : 32'd0;
    e.fc = r ? acc_f : 32'd0;
`else
    e.sc = 32'd0;
    e.fc = 32'd0;
`endif
    q.push_back(e);
    if (r) begin
      acc_s = acc_s + 32'(eo[8]);
      acc_f = acc_f + 32'(eo[5]);
    end else begin
      acc_s = 0;
      acc_f = 0;
    end
    vec++;
  endtask

  // Monitor: outputs are presented every cycle once stimulus has started
  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      logic [8:0] got;
      e   = q.pop_front();
      got = {stall_pc, stall_ifid, stall_idie, flush_ifid, flush_idie,
             bubble_exmem, mul_done, state_o};
      total++;
      if (got === e.o && stall_cnt === e.sc && flush_cnt === e.fc)
        passed++;
      else
        $display("FAIL vec%0d outs got=%b exp=%b stall_cnt got=%0d exp=%0d flush_cnt got=%0d exp=%0d",
                 e.idx, got, e.o, stall_cnt, e.sc, flush_cnt, e.fc);
    end
  end

  initial begin
    rst = 1'b0; Raa_id = 0; Rba_id = 0; Rd_ex = 0;
    memRead_ex = 0; jump_ex = 0; mulStart_ex = 0; mem_busy = 0;
    // reset, including stimulus that would otherwise stall
    cyc(0, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NONE);
    cyc(0, 5'd5, 5'd0, 5'd5, 1, 1, 1, 1, NONE);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NONE);
    // load-use on Raa, then normal flow
    cyc(1, 5'd5, 5'd0, 5'd5, 1, 0, 0, 0, LU);
    cyc(1, 5'd5, 5'd0, 5'd5, 0, 0, 0, 0, NONE);
    // load-use on Rba
    cyc(1, 5'd1, 5'd7, 5'd7, 1, 0, 0, 0, LU);
    // x0 destination never hazards; no match, no hazard
    cyc(1, 5'd0, 5'd0, 5'd0, 1, 0, 0, 0, NONE);
    cyc(1, 5'd6, 5'd7, 5'd5, 1, 0, 0, 0, NONE);
    // jump wins over load-use
    cyc(1, 5'd5, 5'd0, 5'd5, 1, 1, 0, 0, JMP);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NONE);
    // multiply, MUL_LAT=4: 3 stall cycles then done; jump/load-use ignored in MUL
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MST);
    cyc(1, 5'd5, 5'd0, 5'd5, 1, 1, 1, 0, MSTL);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 0, MSTL);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MDONE);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NONE);
    // multiply with 2 cycles of mem_busy in the middle: 5 stall cycles
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MST);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MSTL);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, BMUL);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 1, 1, 1, BMUL);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MSTL);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MDONE);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NONE);
    // mem_busy defers a jump in RUN
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 1, BRUN);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 1, 0, 0, JMP);
    // mem_busy blocks a multiply start; it starts once busy drops
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 1, BRUN);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MST);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, MSTL);
    // reset mid-multiply abandons it
    cyc(0, 5'd0, 5'd0, 5'd0, 0, 0, 1, 0, NONE);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NONE);
    cyc(1, 5'd3, 5'd0, 5'd3, 1, 0, 0, 0, LU);
    cyc(1, 5'd0, 5'd0, 5'd0, 0, 0, 0, 0, NONE);
    repeat (2) @(posedge clk);
    if (q.size() != 0) begin
      total++;
      $display("FAIL drain pending got=%0d exp=0", q.size());
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog timeout got=running exp=finished");
    $fatal(1, "timeout");
  end

endmodule
